// File: rtl/lstm_mv_scheduler_pkg.sv
// lstm_pe_pkg: shared types and helpers for the LSTM PE matrix-vector scheduler.
//   sched_state_e : scheduler FSM state encoding
//   DEF_DATA_W    : default signed data width
//   sat_add       : DEF_DATA_W-bit signed add clamped to the representable range
//                   (used by the output stage when LSTM_SAT_EN is defined)
package lstm_pe_pkg;

  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    MAC    = 3'd2,
    DRAIN  = 3'd3,
    BFETCH = 3'd4,
    OUT    = 3'd5
  } sched_state_e;

  // Sign-extend by one bit, add, and clamp when the two top bits disagree.
  function automatic logic [DEF_DATA_W-1:0] sat_add(input logic [DEF_DATA_W-1:0] a,
                                                    input logic [DEF_DATA_W-1:0] b);
    logic [DEF_DATA_W:0] s;
    s = {a[DEF_DATA_W-1], a} + {b[DEF_DATA_W-1], b};
    if (s[DEF_DATA_W] != s[DEF_DATA_W-1])
      return s[DEF_DATA_W] ? {1'b1, {(DEF_DATA_W-1){1'b0}}} : {1'b0, {(DEF_DATA_W-1){1'b1}}};
    return s[DEF_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/lstm_mv_scheduler_if.sv
// lstm_mv_scheduler_if: result stream (valid/ready) from the scheduler to downstream.
//   res_valid : result valid          (master -> slave)
//   res_ready : downstream accepts    (slave -> master)
//   res_data  : biased accumulator    (master -> slave)
//   res_idx   : output row of res_data (master -> slave)
interface lstm_mv_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 9
);
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [IDX_W-1:0]  res_idx;

  modport master (output res_valid, output res_data, output res_idx, input res_ready);
  modport slave  (input res_valid, input res_data, input res_idx, output res_ready);
endinterface

// File: rtl/lstm_mv_scheduler_out_stage.sv
// lstm_mv_out_stage: bias add and valid/ready result register.
//   clk, rst_n : clock, async active-low reset
//   valid      : scheduler is presenting a result (OUT state)
//   load       : first OUT cycle; acc/bias are valid, the sum is captured
//   idx_in     : output row of the current lane
//   acc, bias  : lane accumulator and bias word
//   res        : result stream (master)
// Build option LSTM_SAT_EN: saturating add instead of two's-complement wrap.
// On the load cycle the sum is forwarded directly so the result is offered
// the same cycle the bias word arrives; afterwards the registered copy holds
// it stable through any backpressure.
module lstm_mv_out_stage
  import lstm_pe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              load,
  input  logic [IDX_W-1:0]  idx_in,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] bias,
  lstm_mv_scheduler_if.master res
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] data_q;
  logic [IDX_W-1:0]  idx_q;

`ifdef LSTM_SAT_EN
  if (DATA_W != DEF_DATA_W) begin : g_sat_width_chk
    $error("saturating add is built for DEF_DATA_W-wide data only");
  end
  assign sum = sat_add(acc, bias);
`else
  assign sum = acc + bias;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      data_q <= sum;
      idx_q  <= idx_in;
    end
  end

  assign res.res_valid = valid;
  assign res.res_data  = load ? sum : data_q;
  assign res.res_idx   = load ? idx_in : idx_q;

endmodule

// File: rtl/lstm_mv_scheduler.sv
// lstm_mv_scheduler: sequences the LSTM PE matrix-vector datapath,
// result[r] = sum_k W[r][k]*x[k] + b[r], in tiles of LANES rows.
//   clk, rst_n        : clock, async active-low reset
//   start, abort      : begin a pass (IDLE only) / return to IDLE, no done
//   busy, done        : not IDLE / 1-cycle pulse after the last result
//   rd_en, vec_addr, w_addr : vector+weight read (1-cycle latency)
//   mac_clr, mac_en, mac_last : MAC array control
//   acc_in            : LANES accumulators, lane l at [l*DATA_W +: DATA_W]
//   b_rd_en, b_addr, b_data : bias read (1-cycle latency)
//   res               : result stream (master modport)
// Build option LSTM_SAT_EN: saturating bias add (see lstm_mv_out_stage).
//
// state  | meaning
// IDLE   | waiting for start
// CLR    | clear accumulators, k := 0
// MAC    | stream IN_LEN vector/weight reads
// DRAIN  | last accumulate lands (mac_last), lane := 0
// BFETCH | read bias for tile*LANES+lane
// OUT    | present result, wait for handshake
module lstm_mv_scheduler
  import lstm_pe_pkg::*;
#(
  parameter int IN_LEN  = 100,
  parameter int OUT_LEN = 400,
  parameter int LANES   = 4,
  parameter int DATA_W  = DEF_DATA_W,
  localparam int NTILES = OUT_LEN / LANES,
  localparam int K_W    = (IN_LEN > 1) ? $clog2(IN_LEN) : 1,
  localparam int WA_W   = (NTILES * IN_LEN > 1) ? $clog2(NTILES * IN_LEN) : 1,
  localparam int B_W    = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1,
  localparam int L_W    = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int T_W    = (NTILES > 1) ? $clog2(NTILES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [K_W-1:0]          vec_addr,
  output logic [WA_W-1:0]         w_addr,
  output logic                    mac_clr,
  output logic                    mac_en,
  output logic                    mac_last,
  input  logic [LANES*DATA_W-1:0] acc_in,
  output logic                    b_rd_en,
  output logic [B_W-1:0]          b_addr,
  input  logic [DATA_W-1:0]       b_data,
  lstm_mv_scheduler_if.master     res
);

  if (OUT_LEN % LANES != 0) begin : g_len_chk
    $error("OUT_LEN must be a multiple of LANES");
  end

  sched_state_e      state_q, state_d;
  logic [K_W-1:0]    k_q;
  logic [L_W-1:0]    lane_q;
  logic [T_W-1:0]    tile_q;
  logic              out_first_q, mac_en_q, mac_last_q, done_q;
  logic              k_last, lane_last, tile_last, hs;
  logic [DATA_W-1:0] acc_lane;

  assign k_last    = (k_q == K_W'(IN_LEN - 1));
  assign lane_last = (lane_q == L_W'(LANES - 1));
  assign tile_last = (tile_q == T_W'(NTILES - 1));
  assign hs        = (state_q == OUT) && res.res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = CLR;
        CLR:     state_d = MAC;
        MAC:     if (k_last) state_d = DRAIN;
        DRAIN:   state_d = BFETCH;
        BFETCH:  state_d = OUT;
        OUT: begin
          if (hs) begin
            if (!lane_last)      state_d = BFETCH;
            else if (!tile_last) state_d = CLR;
            else                 state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state_q != IDLE);
    rd_en   = (state_q == MAC);
    mac_clr = (state_q == CLR);
    b_rd_en = (state_q == BFETCH);
  end

  // Counters and the registered strobes. Abort masks every strobe so they all
  // drop together with the return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q         <= '0;
      lane_q      <= '0;
      tile_q      <= '0;
      out_first_q <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mac_en_q    <= rd_en && !abort;
      mac_last_q  <= (state_q == MAC) && k_last && !abort;
      done_q      <= hs && lane_last && tile_last && !abort;
      out_first_q <= (state_q == BFETCH) && !abort;
      if (!abort) begin
        case (state_q)
          IDLE:  if (start) tile_q <= '0;
          CLR:   k_q <= '0;
          MAC:   if (!k_last) k_q <= k_q + 1'b1;
          DRAIN: lane_q <= '0;
          OUT: begin
            if (hs) begin
              if (!lane_last)      lane_q <= lane_q + 1'b1;
              else if (!tile_last) tile_q <= tile_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign vec_addr = k_q;
  assign w_addr   = WA_W'(int'(tile_q) * IN_LEN + int'(k_q));
  assign b_addr   = B_W'(int'(tile_q) * LANES + int'(lane_q));
  assign mac_en   = mac_en_q;
  assign mac_last = mac_last_q;
  assign done     = done_q;
  assign acc_lane = acc_in[int'(lane_q) * DATA_W +: DATA_W];

  lstm_mv_out_stage #(
    .DATA_W (DATA_W),
    .IDX_W  (B_W)
  ) u_out (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  (state_q == OUT),
    .load   (out_first_q),
    .idx_in (b_addr),
    .acc    (acc_lane),
    .bias   (b_data),
    .res    (res)
  );

endmodule

// File: tb/tb_lstm_mv_scheduler.sv
// Bench for lstm_mv_scheduler at IN_LEN=4, OUT_LEN=8, LANES=4. Models the
// vector/weight/bias SRAMs (1-cycle latency) and the MAC array, and checks the
// result stream against results computed directly from W, x and b.
module tb_lstm_mv_scheduler;
  localparam int IN_LEN  = 4;
  localparam int OUT_LEN = 8;
  localparam int LANES   = 4;
  localparam int DATA_W  = 32;
  localparam int KW = 2, WAW = 3, BW = 3;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic busy, done, rd_en, mac_clr, mac_en, mac_last, b_rd_en;
  logic [KW-1:0] vec_addr;
  logic [WAW-1:0] w_addr;
  logic [BW-1:0] b_addr;
  logic [LANES*DATA_W-1:0] acc_in;
  logic [DATA_W-1:0] b_data;

  lstm_mv_scheduler_if #(.DATA_W(DATA_W), .IDX_W(BW)) res_if ();

  lstm_mv_scheduler #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .LANES(LANES), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .rd_en(rd_en), .vec_addr(vec_addr), .w_addr(w_addr), .mac_clr(mac_clr), .mac_en(mac_en),
    .mac_last(mac_last), .acc_in(acc_in), .b_rd_en(b_rd_en), .b_addr(b_addr), .b_data(b_data),
    .res(res_if)
  );

  initial forever #5 clk = ~clk;

  // memories and MAC array
  logic [31:0] xv [IN_LEN];
  logic [31:0] wm [OUT_LEN][IN_LEN];
  logic [31:0] bv [OUT_LEN];
  logic [31:0] x_q, b_q;
  logic [31:0] w_q [LANES];
  logic [31:0] acc [LANES];

  always @(posedge clk) begin
    if (rd_en) begin
      x_q <= xv[vec_addr];
      for (int l = 0; l < LANES; l++)
        w_q[l] <= wm[(int'(w_addr) / IN_LEN) * LANES + l][int'(w_addr) % IN_LEN];
    end
    if (b_rd_en) b_q <= bv[b_addr];
    if (mac_clr) for (int l = 0; l < LANES; l++) acc[l] <= 32'h0;
    else if (mac_en) for (int l = 0; l < LANES; l++) acc[l] <= acc[l] + w_q[l] * x_q;
  end

  always_comb begin
    acc_in = '0;
    for (int l = 0; l < LANES; l++) acc_in[l*DATA_W +: DATA_W] = acc[l];
  end
  assign b_data = b_q;

  // scoreboard
  int n_cmp = 0, n_bad = 0;
  int got_i[$];
  logic [31:0] got_d[$];
  int hs_cyc[$];
  int done_cnt, done_cyc, busy_cnt;
  logic [31:0] exp_row [OUT_LEN];

  typedef struct {
    logic [31:0] acc;
    logic [31:0] bias;
    logic [31:0] e_wrap;
    logic [31:0] e_sat;
  } vec_t;
  vec_t tbl [OUT_LEN];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] s;
    s = 64'($signed(a)) + 64'($signed(b));
`ifdef LSTM_SAT_EN
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[31:0];
  endfunction

  function automatic logic [31:0] model_row(input int r);
    logic [31:0] a;
    a = 32'h0;
    for (int k = 0; k < IN_LEN; k++) a = a + wm[r][k] * xv[k];
    return ref_add(a, bv[r]);
  endfunction

  task automatic fill_spec();
    for (int k = 0; k < IN_LEN; k++) xv[k] = 32'(k + 1);
    for (int r = 0; r < OUT_LEN; r++) begin
      for (int k = 0; k < IN_LEN; k++) wm[r][k] = 32'(r + 1);
      bv[r] = 32'(r * 10);
      exp_row[r] = 32'(20 * r + 10);
    end
  endtask

  // One pass: start, optional stall on stall_idx, optional abort, optional
  // start held high (stops one cycle after done to see the restart).
  task automatic run_pass(input int budget, input bit rnd_ready, input int stall_idx,
                          input int stall_len, input int abort_cyc, input bit hold_start);
    int stall_left;
    bit stall_active;
    logic [31:0] hold_d;
    int hold_i;
    got_i.delete(); got_d.delete(); hs_cyc.delete();
    done_cnt = 0; done_cyc = -1; busy_cnt = 0;
    stall_left = stall_len; stall_active = 0; hold_d = 0; hold_i = 0;
    @(posedge clk); #1;
    start = 1'b1;
    res_if.res_ready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (!hold_start) start = 1'b0;
      abort = (c == abort_cyc);
      if (res_if.res_valid && int'(res_if.res_idx) == stall_idx && stall_left > 0) begin
        if (!stall_active) begin
          hold_d = res_if.res_data; hold_i = int'(res_if.res_idx); stall_active = 1;
        end
        res_if.res_ready = 1'b0;
        stall_left--;
      end else begin
        res_if.res_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(negedge clk);
      if (busy) busy_cnt++;
      if (stall_active) begin
        chk("stall_valid", res_if.res_valid, 1);
        chk("stall_data", res_if.res_data, hold_d);
        chk("stall_idx", res_if.res_idx, hold_i);
      end
      if (res_if.res_valid && res_if.res_ready) begin
        got_i.push_back(int'(res_if.res_idx));
        got_d.push_back(res_if.res_data);
        hs_cyc.push_back(c);
        stall_active = 0;
      end
      if (done) begin done_cnt++; done_cyc = c; end
      if (abort_cyc >= 0 && c == abort_cyc + 1) begin
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", rd_en, 0);
        chk("abort_mac_en", mac_en, 0);
        chk("abort_b_rd_en", b_rd_en, 0);
        chk("abort_res_valid", res_if.res_valid, 0);
      end
      if (abort_cyc >= 0 && c == abort_cyc + 4) break;
      if (hold_start && done_cyc >= 0 && c == done_cyc + 1) begin
        chk("restart_busy", busy, 1);
        chk("restart_clr", mac_clr, 1);
        break;
      end
      if (!hold_start && done_cyc >= 0 && c == done_cyc + 2) break;
    end
    abort = 1'b0;
    res_if.res_ready = 1'b1;
  endtask

  task automatic check_rows(input string tag);
    chk({tag, "_count"}, got_i.size(), OUT_LEN);
    for (int i = 0; i < got_i.size() && i < OUT_LEN; i++) begin
      chk({tag, "_idx"}, got_i[i], i);
      chk({tag, "_data"}, got_d[i], exp_row[i]);
    end
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    if (hs_cyc.size() > 0 && done_cnt > 0)
      chk({tag, "_done_gap"}, done_cyc - hs_cyc[hs_cyc.size()-1], 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'h7FFF_FFF0, 32'h0000_0100, 32'h8000_00F0, 32'h7FFF_FFFF};
    tbl[1] = '{32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 32'h0000_000C};
    tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
    tbl[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    tbl[4] = '{32'h8000_0010, 32'hFFFF_FF00, 32'h7FFF_FF10, 32'h8000_0000};
    tbl[5] = '{32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 32'h2345_6789};
    tbl[6] = '{32'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    tbl[7] = '{32'h4000_0000, 32'h4000_0000, 32'h8000_0000, 32'h7FFF_FFFF};

    res_if.res_ready = 1'b1;
    fill_spec();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_mac_clr", mac_clr, 0);
    chk("rst_b_rd_en", b_rd_en, 0);
    chk("rst_res_valid", res_if.res_valid, 0);
    chk("rst_res_data", res_if.res_data, 0);
    rst_n = 1'b1;

    // start and abort together in IDLE: stay idle
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", busy, 0);

    // basic pass
    run_pass(200, 0, -1, 0, -1, 0);
    check_rows("basic");
    check_done("basic");
    chk("basic_busy_cycles", busy_cnt, 2 * (IN_LEN + 2 + 2 * LANES));

    // backpressure on idx 2
    run_pass(200, 0, 2, 5, -1, 0);
    check_rows("stall");
    check_done("stall");
    chk("stall_busy_cycles", busy_cnt, 2 * (IN_LEN + 2 + 2 * LANES) + 5);

    // table of bias-add corner values, one per row
    for (int r = 0; r < OUT_LEN; r++) begin
      for (int k = 0; k < IN_LEN; k++) wm[r][k] = (k == 0) ? tbl[r].acc : 32'h0;
      bv[r] = tbl[r].bias;
`ifdef LSTM_SAT_EN
      exp_row[r] = tbl[r].e_sat;
`else
      exp_row[r] = tbl[r].e_wrap;
`endif
    end
    for (int k = 0; k < IN_LEN; k++) xv[k] = (k == 0) ? 32'h1 : 32'h0;
    run_pass(200, 0, -1, 0, -1, 0);
    check_rows("table");
    check_done("table");

    // abort during tile 1 MAC, then a clean pass
    fill_spec();
    run_pass(200, 0, -1, 0, 16, 0);
    chk("abort_done_cnt", done_cnt, 0);
    chk("abort_rows", got_i.size(), LANES);
    run_pass(200, 0, -1, 0, -1, 0);
    check_rows("post_abort");
    check_done("post_abort");

    // reset asserted during OUT
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("rst_pre_valid", res_if.res_valid, 1);
    chk("rst_pre_data", res_if.res_data, 10);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_res_valid", res_if.res_valid, 0);
    chk("arst_res_data", res_if.res_data, 0);
    chk("arst_res_idx", res_if.res_idx, 0);
    chk("arst_b_addr", b_addr, 0);
    chk("arst_w_addr", w_addr, 0);
    chk("arst_strobes", {rd_en, mac_en, mac_clr, mac_last, b_rd_en, done}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
    end

    // start held high: exactly one pass, restart right after done
    run_pass(200, 0, -1, 0, -1, 1);
    check_rows("hold");
    check_done("hold");
    start = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("hold_abort_busy", busy, 0);

    // random data and random backpressure against the direct model
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < IN_LEN; k++) xv[k] = ($urandom_range(0, 1) != 0) ? $urandom() : $urandom_range(0, 255);
      for (int r = 0; r < OUT_LEN; r++) begin
        for (int k = 0; k < IN_LEN; k++) wm[r][k] = ($urandom_range(0, 1) != 0) ? $urandom() : $urandom_range(0, 255);
        bv[r] = $urandom();
      end
      for (int r = 0; r < OUT_LEN; r++) exp_row[r] = model_row(r);
      run_pass(2000, 1, -1, 0, -1, 0);
      check_rows("rand");
      check_done("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
